collision_scheduler: RTL and testbench

- Time-multiplexes the single registered collision checker across a table of ground tiles, one tile per clock.
- On each start pulse (one per frame, from game logic), it latches the blue sprite position.
- It then streams every tile from the tile table through the checker and OR-accumulates the four side flags.
- It publishes the frame's aggregate flags, plus the index of the first landing tile, with a done pulse.

---
 rtl/collision_scheduler.sv | 150 +++++++++++++++
 tb/tb_collision_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/collision_scheduler.sv
// Frame-level collision scan: streams the tile table through one registered
// collision checker and publishes the OR of side flags plus the first landing tile.
module collision_scheduler #(
  parameter int N_TILES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       x_blue,
  input  logic [8:0]       y_blue,
  output logic [IDX_W-1:0] tile_addr,
  input  logic [9:0]       tile_x,
  input  logic [8:0]       tile_y,
  input  logic             tile_valid,
  output logic [9:0]       chk_x_blue,
  output logic [8:0]       chk_y_blue,
  output logic [9:0]       chk_x_ground,
  output logic [8:0]       chk_y_ground,
  input  logic [3:0]       chk_flags,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags,
  output logic             land_valid,
  output logic [IDX_W-1:0] land_idx
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);

  state_t           state_q;
  logic [IDX_W-1:0] addr_q;
  logic [9:0]       xb_q;
  logic [8:0]       yb_q;
  logic             drain_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       flags_q;
  logic             land_valid_q;
  logic [IDX_W-1:0] land_idx_q;

  // s1: table data for an issued address is on tile_*; s2: checker result is on chk_flags
  logic             s1_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s2_q;
  logic [IDX_W-1:0] s2_idx_q;

  logic [3:0]       acc_q, acc_d;
  logic             landv_q, landv_d;
  logic [IDX_W-1:0] landi_q, landi_d;

  always_comb begin
    acc_d   = acc_q;
    landv_d = landv_q;
    landi_d = landi_q;
    if (s2_q) begin
      acc_d = acc_q | chk_flags;
      if (chk_flags[0] && !landv_q) begin
        landv_d = 1'b1;
        landi_d = s2_idx_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      xb_q         <= '0;
      yb_q         <= '0;
      drain_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      flags_q      <= '0;
      land_valid_q <= 1'b0;
      land_idx_q   <= '0;
      s1_q         <= 1'b0;
      s1_idx_q     <= '0;
      s2_q         <= 1'b0;
      s2_idx_q     <= '0;
      acc_q        <= '0;
      landv_q      <= 1'b0;
      landi_q      <= '0;
    end else begin
      done_q   <= 1'b0;
      s1_q     <= (state_q == SCAN);
      s1_idx_q <= addr_q;
      s2_q     <= s1_q & tile_valid;
      s2_idx_q <= s1_idx_q;
      acc_q    <= acc_d;
      landv_q  <= landv_d;
      landi_q  <= landi_d;

      case (state_q)
        IDLE: begin
          if (start) begin
            xb_q    <= x_blue;
            yb_q    <= y_blue;
            acc_q   <= '0;
            landv_q <= 1'b0;
            landi_q <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (addr_q == LAST_IDX) begin
            drain_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          // Second drain cycle carries the last tile's result; publish the merged value.
          if (drain_q) begin
            drain_q      <= 1'b0;
            done_q       <= 1'b1;
            flags_q      <= acc_d;
            land_valid_q <= landv_d;
            land_idx_q   <= landv_d ? landi_d : '0;
            state_q      <= DONE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          addr_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tile_addr    = addr_q;
  assign chk_x_blue   = xb_q;
  assign chk_y_blue   = yb_q;
  assign chk_x_ground = tile_x;
  assign chk_y_ground = tile_y;
  assign busy         = busy_q;
  assign done         = done_q;
  assign flags        = flags_q;
  assign land_valid   = land_valid_q;
  assign land_idx     = land_idx_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: behavioural tile table and checker stub,
// vector table of frame scenarios, scoreboard of expected frame results.
module tb_collision_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x_blue = '0;
  logic [8:0] y_blue = '0;
  logic [3:0] tile_addr;
  logic [9:0] tile_x;
  logic [8:0] tile_y;
  logic       tile_valid;
  logic [9:0] chk_x_blue;
  logic [8:0] chk_y_blue;
  logic [9:0] chk_x_ground;
  logic [8:0] chk_y_ground;
  logic [3:0] chk_flags;
  logic       busy;
  logic       done;
  logic [3:0] flags;
  logic       land_valid;
  logic [3:0] land_idx;

  collision_scheduler #(.N_TILES(16), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x_blue(x_blue), .y_blue(y_blue),
    .tile_addr(tile_addr), .tile_x(tile_x), .tile_y(tile_y), .tile_valid(tile_valid),
    .chk_x_blue(chk_x_blue), .chk_y_blue(chk_y_blue),
    .chk_x_ground(chk_x_ground), .chk_y_ground(chk_y_ground),
    .chk_flags(chk_flags), .busy(busy), .done(done), .flags(flags),
    .land_valid(land_valid), .land_idx(land_idx)
  );

  always #5 clk = ~clk;

  // Tile i stores x=i so the checker stub can recover the tile identity.
  logic [63:0] cur_resp  = '0;
  logic [15:0] cur_valid = '0;
  always_ff @(posedge clk) begin
    tile_x     <= 10'(tile_addr);
    tile_y     <= 9'(tile_addr) + 9'd40;
    tile_valid <= cur_valid[tile_addr];
    chk_flags  <= cur_resp[4*int'(chk_x_ground[3:0]) +: 4];
  end

  typedef struct {
    logic [9:0]  xb;
    logic [8:0]  yb;
    logic [63:0] resp;
    logic [15:0] vld;
    logic [3:0]  ef;
    logic        elv;
    logic [3:0]  eli;
  } vec_t;

  typedef struct {
    logic [3:0] f;
    logic       lv;
    logic [3:0] li;
  } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  int   passed = 0;
  int   total  = 0;
  logic [3:0] prev_flags = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
  endtask

  function automatic logic [33:0] out_bundle();
    return {tile_addr, chk_x_blue, chk_y_blue, busy, done, flags, land_valid, land_idx};
  endfunction

  task automatic compare_done();
    exp_t e;
    chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("flags", 64'(flags), 64'(e.f));
      chk("land_valid", 64'(land_valid), 64'(e.lv));
      chk("land_idx", 64'(land_idx), 64'(e.li));
      prev_flags = e.f;
    end
  endtask

  task automatic push_exp(input int vi);
    exp_t e;
    e.f = vecs[vi].ef; e.lv = vecs[vi].elv; e.li = vecs[vi].eli;
    sbq.push_back(e);
  endtask

  task automatic run_scan(input int vi);
    int done_c = -1;
    cur_resp  = vecs[vi].resp;
    cur_valid = vecs[vi].vld;
    @(negedge clk);
    start  = 1'b1;
    x_blue = vecs[vi].xb;
    y_blue = vecs[vi].yb;
    push_exp(vi);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (c == 5) begin
        x_blue = 10'd300;
        y_blue = 9'd311;
      end
      if (c <= 19) begin
        chk("chk_x_blue", 64'(chk_x_blue), 64'(vecs[vi].xb));
        chk("chk_y_blue", 64'(chk_y_blue), 64'(vecs[vi].yb));
      end
      if (c <= 18) chk("tile_addr", 64'(tile_addr), (c <= 16) ? 64'(c - 1) : 64'd15);
      chk("busy", 64'(busy), 64'(c <= 19));
      chk("ground_x_passthru", 64'(chk_x_ground), 64'(tile_x));
      if (done) begin
        if (done_c < 0) done_c = c;
        compare_done();
      end else begin
        chk("flags_hold", 64'(flags), 64'(prev_flags));
      end
      @(negedge clk);
    end
    chk("done_cycle", 64'(done_c), 64'(19));
  endtask

  initial begin
    // landing on tile 5 only
    vecs[0] = '{10'd100, 9'd200, 64'h0000_0000_0010_0000, 16'hFFFF, 4'b0001, 1'b1, 4'd5};
    // landings on 3 and 9, right on 12, left on empty slot 7
    vecs[1] = '{10'd17,  9'd33,  64'h0004_0010_8000_1000, 16'hFF7F, 4'b0101, 1'b1, 4'd3};
    // no hits at all
    vecs[2] = '{10'd512, 9'd256, 64'h0000_0000_0000_0000, 16'hFFFF, 4'b0000, 1'b0, 4'd0};
    // boundary tiles 0 and 15
    vecs[3] = '{10'd1,   9'd2,   64'h3000_0000_0000_0001, 16'hFFFF, 4'b0011, 1'b1, 4'd0};
    // landing only counts on tile 15; tile 2 slot is empty
    vecs[4] = '{10'd1023, 9'd511, 64'h1000_0000_0000_0100, 16'hFFFB, 4'b0001, 1'b1, 4'd15};
    // every tile reports all sides but every slot is empty
    vecs[5] = '{10'd77,  9'd88,  64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 4'b0000, 1'b0, 4'd0};

    #3 rst = 1'b1;
    #9 rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("idle_outputs", 64'(out_bundle()), 64'd0);
    end

    for (int vi = 0; vi < 6; vi++) run_scan(vi);

    // start held high: a new frame every 20 cycles
    begin
      int n_done = 0;
      int first_c = -1;
      int second_c = -1;
      cur_resp  = vecs[0].resp;
      cur_valid = vecs[0].vld;
      @(negedge clk);
      start  = 1'b1;
      x_blue = vecs[0].xb;
      y_blue = vecs[0].yb;
      push_exp(0);
      push_exp(0);
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (done) begin
          n_done++;
          if (first_c < 0) first_c = c; else if (second_c < 0) second_c = c;
          compare_done();
        end
        if (c == 39) start = 1'b0;
      end
      chk("held_done_count", 64'(n_done), 64'd2);
      chk("held_first_done", 64'(first_c), 64'd19);
      chk("held_second_done", 64'(second_c), 64'd39);
      repeat (3) @(negedge clk);
      chk("held_idle_busy", 64'(busy), 64'd0);
    end

    // reset in the middle of a scan
    cur_resp  = vecs[0].resp;
    cur_valid = vecs[0].vld;
    @(negedge clk);
    start  = 1'b1;
    x_blue = 10'd400;
    y_blue = 9'd123;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_scan_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("reset_clears", 64'(out_bundle()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_flags = '0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk("post_reset_quiet", 64'(out_bundle()), 64'd0);
    end
    run_scan(1);
    run_scan(2);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
